sync_fifo_prog: RTL and testbench

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_prog.sv | 108 ++++++++++
 tb/tb_sync_fifo_prog.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog
// Brief    : Synchronous FIFO with programmable almost flags, sticky errors,
//            and selectable registered-read / first-word-fall-through output.
// Revision : 1.0
// ============================================================================
module sync_fifo_prog #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   r_en,
    input  logic [$clog2(DEPTH):0] af_thresh,
    input  logic [$clog2(DEPTH):0] ae_thresh,
    input  logic                   clr_err,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_set;
    logic w_udf_set;

    assign full         = (r_count == C_DEPTH);
    assign empty        = (r_count == '0);
    assign count        = r_count;
    assign almost_full  = (r_count >= af_thresh);
    assign almost_empty = (r_count <= ae_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc  = w_en & ~full;
    assign w_rd_acc  = r_en & ~empty;
    // A simultaneous read/write at a boundary is a legal pass-through, not an error.
    assign w_ovf_set = w_en & full & ~r_en;
    assign w_udf_set = r_en & empty & ~w_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end
            r_overflow  <= (r_overflow  & ~clr_err) | w_ovf_set;
            r_underflow <= (r_underflow & ~clr_err) | w_udf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
            assign data_out = r_dout;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_prog
// Brief    : Queue-model bench driving a registered-read and an FWFT instance.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_prog;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          w_en;
    logic [DW-1:0] data_in;
    logic          r_en;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic          clr_err;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [CW-1:0] s_count, f_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_prog #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue holding the FIFO contents in write order.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    bit            m_ovf, m_udf, m_valid = 0;

    always @(posedge clk) begin
        int  n;
        bit  mfull, mempty;
        if (!rst_n) begin
            mq.delete();
            m_dout  = '0;
            m_ovf   = 0;
            m_udf   = 0;
            m_valid = 1;
        end else begin
            n      = mq.size();
            mfull  = (n == DEPTH);
            mempty = (n == 0);
            m_ovf  = (m_ovf && !clr_err) || (w_en && mfull && !r_en);
            m_udf  = (m_udf && !clr_err) || (r_en && mempty && !w_en);
            if (r_en && !mempty) m_dout = mq.pop_front();
            if (w_en && !mfull)  mq.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        int n;
        if (m_valid) begin
            n = mq.size();
            chk("std_count", 32'(s_count), 32'(n));
            chk("fwft_count", 32'(f_count), 32'(n));
            chk("std_full", 32'(s_full), 32'(n == DEPTH));
            chk("fwft_full", 32'(f_full), 32'(n == DEPTH));
            chk("std_empty", 32'(s_empty), 32'(n == 0));
            chk("fwft_empty", 32'(f_empty), 32'(n == 0));
            chk("std_af", 32'(s_af), 32'(n >= int'(af_thresh)));
            chk("fwft_af", 32'(f_af), 32'(n >= int'(af_thresh)));
            chk("std_ae", 32'(s_ae), 32'(n <= int'(ae_thresh)));
            chk("fwft_ae", 32'(f_ae), 32'(n <= int'(ae_thresh)));
            chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
            chk("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
            chk("std_udf", 32'(s_udf), 32'(m_udf));
            chk("fwft_udf", 32'(f_udf), 32'(m_udf));
            chk("std_dout", 32'(s_dout), 32'(m_dout));
            if (n > 0) chk("fwft_dout", 32'(f_dout), 32'(mq[0]));
        end
    end

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        #1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        w_en      = 1'b0;
        r_en      = 1'b0;
        data_in   = '0;
        clr_err   = 1'b0;
        af_thresh = 5'd12;
        ae_thresh = 5'd3;

        // Reset, with requests asserted that must be ignored
        step(1'b1, 1'b1, 8'hEE);
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_full", 32'(f_full), 32'd0);
        chk("rst_dout", 32'(s_dout), 32'd0);
        chk("rst_ae", 32'(s_ae), 32'd1);
        chk("rst_af", 32'(f_af), 32'd0);

        // Fill 0x00..0x0F and watch threshold crossings
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 0) chk("fwft_first_word", 32'(f_dout), 32'h00);
            if (i == 2) chk("ae_at_3", 32'(s_ae), 32'd1);
            if (i == 3) chk("ae_at_4", 32'(f_ae), 32'd0);
            if (i == 10) chk("af_at_11", 32'(s_af), 32'd0);
            if (i == 11) chk("af_at_12", 32'(f_af), 32'd1);
        end
        chk("fill_full", 32'(s_full), 32'd1);
        chk("fill_count", 32'(f_count), 32'd16);
        step(1'b1, 1'b0, 8'h99);
        chk("ovf_set", 32'(s_ovf), 32'd1);
        chk("ovf_count", 32'(s_count), 32'd16);

        // Drain in order, then underflow
        for (int i = 0; i < 16; i++) begin
            chk("fwft_head", 32'(f_dout), 32'(i));
            step(1'b0, 1'b1, 8'h00);
            chk("std_read", 32'(s_dout), 32'(i));
        end
        chk("drain_empty", 32'(f_empty), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        chk("udf_set", 32'(s_udf), 32'd1);
        chk("udf_hold_dout", 32'(s_dout), 32'h0F);
        clr_err = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        chk("clr_ovf", 32'(s_ovf), 32'd0);
        chk("clr_udf", 32'(f_udf), 32'd0);

        // Simultaneous requests at full and at empty
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b1, 1'b1, 8'h55);
        chk("both_full_count", 32'(s_count), 32'd15);
        chk("both_full_flag", 32'(s_full), 32'd0);
        chk("both_full_ovf", 32'(s_ovf), 32'd0);
        chk("both_full_dout", 32'(s_dout), 32'h20);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h66);
        chk("both_empty_count", 32'(f_count), 32'd1);
        chk("both_empty_udf", 32'(f_udf), 32'd0);
        chk("both_empty_fwft", 32'(f_dout), 32'h66);
        step(1'b0, 1'b1, 8'h00);
        chk("pass_dout", 32'(s_dout), 32'h66);

        // Steady state at count 8 with pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 8'(8'h88 + i));
            chk("steady_count", 32'(s_count), 32'd8);
            chk("steady_dout", 32'(s_dout), 32'(8'h80 + i));
        end

        // Mid-operation reset with count 9 and overflow set
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
        chk("pre_rst_count", 32'(s_count), 32'd9);
        chk("pre_rst_ovf", 32'(f_ovf), 32'd1);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        chk("mid_rst_count", 32'(f_count), 32'd0);
        chk("mid_rst_empty", 32'(s_empty), 32'd1);
        chk("mid_rst_ovf", 32'(s_ovf), 32'd0);
        step(1'b1, 1'b0, 8'hA5);
        chk("post_rst_fwft", 32'(f_dout), 32'hA5);
        step(1'b0, 1'b1, 8'h00);
        chk("post_rst_std", 32'(s_dout), 32'hA5);
        chk("post_rst_empty", 32'(f_empty), 32'd1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
